// File: rtl/risc_control_unit.sv
// risc_control_unit: instruction decode, CVZN flag register, LOAD/RUN/HALT mode FSM and retired counter.
// Optional ILLEGAL_TRAP_EN: undefined opcodes set a sticky illegal flag and halt.
module risc_control_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             load_req,
    input  logic             start,
    input  logic [15:0]      instr,
    input  logic             Pre_C,
    input  logic             Pre_V,
    input  logic             Pre_Z,
    input  logic             Pre_N,
    output logic             test_normal,
    output logic             clr,
    output logic             flag_HLT,
    output logic             ADC,
    output logic             SUB,
    output logic             SBB,
    output logic             Src_ALU_B,
    output logic             Src_Read_B,
    output logic             JMP,
    output logic             BRANCH,
    output logic             flag_label_PC,
    output logic             flag_Rm_PC,
    output logic             flag_Rd_PC,
    output logic             data_write_en,
    output logic             RF_write_en,
    output logic             flag_mem_RF,
    output logic             flag_ALU_RF,
    output logic             flag_Rm_RF,
    output logic             flag_PC_RF,
    output logic             LHI,
    output logic             LLI,
    output logic             flag_OutR,
    output logic [3:0]       flags_q,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);
    typedef enum logic [1:0] {LOAD, RUN, HALT} state_e;

    state_e           state_q, state_d;
    logic             clr_q, clr_d, illegal_q, illegal_d;
    logic [3:0]       flags_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [4:0]       op;
    logic [2:0]       cond;
    logic [1:0]       fn;
    logic             exec, base, taken, unused_fields;
    logic             alu, lhi, lli, ldr, str, bcc, jmpl, jmpr, jal, outr, hlt;

    assign op            = instr[15:11];
    assign cond          = instr[10:8];
    assign fn            = instr[1:0];
    assign unused_fields = ^instr[7:2];

    // exec marks a RUN cycle that actually executes (not the PC-clear cycle)
    assign exec = (state_q == RUN) && !clr_q;
    assign alu  = exec && op == 5'b00000;
    assign lhi  = exec && op == 5'b00001;
    assign lli  = exec && op == 5'b00010;
    assign ldr  = exec && op == 5'b00011;
    assign str  = exec && op == 5'b00101;
    assign bcc  = exec && op == 5'b11000;
    assign jmpl = exec && op == 5'b11001;
    assign jmpr = exec && op == 5'b11010;
    assign jal  = exec && op == 5'b11011;
    assign outr = exec && op == 5'b11100;
    assign hlt  = exec && op == 5'b11111;

    // flags_q = {C,V,Z,N}; odd conditions are the negated form of the even ones
    assign base  = cond[2:1] == 2'd0 ? flags_q[1] :
                   cond[2:1] == 2'd1 ? flags_q[3] :
                   cond[2:1] == 2'd2 ? flags_q[0] : flags_q[2];
    assign taken = (&cond) | (base ^ cond[0]);

    assign test_normal   = state_q == LOAD;
    assign clr           = (state_q == RUN) && clr_q;
    assign flag_HLT      = exec;
    assign halted        = state_q == HALT;
    assign ADC           = alu && fn == 2'b01;
    assign SUB           = alu && fn == 2'b10;
    assign SBB           = alu && fn == 2'b11;
    assign Src_ALU_B     = ldr | str;
    assign Src_Read_B    = lhi | str;
    assign JMP           = jmpl | jmpr | jal;
    assign BRANCH        = bcc && taken;
    assign flag_label_PC = (bcc && taken) | jmpl | jal;
    assign flag_Rm_PC    = jmpr;
    assign flag_Rd_PC    = 1'b0;
    // a pending LOAD request cancels the architectural writes of the current instruction
    assign data_write_en = str && !load_req;
    assign RF_write_en   = !load_req && (alu | lhi | lli | ldr | jal);
    assign flag_mem_RF   = ldr;
    assign flag_ALU_RF   = alu;
    assign flag_Rm_RF    = 1'b0;
    assign flag_PC_RF    = jal;
    assign LHI           = lhi;
    assign LLI           = lli;
    assign flag_OutR     = outr;
    assign retired       = retired_q;
    assign illegal       = illegal_q;

`ifdef ILLEGAL_TRAP_EN
    logic known;
    assign known = alu | lhi | lli | ldr | str | bcc | jmpl | jmpr | jal | outr | hlt;
`endif

    always_comb begin
        state_d   = state_q;
        clr_d     = 1'b0;
        flags_d   = flags_q;
        retired_d = retired_q;
        illegal_d = illegal_q;
        if (exec) begin
            retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (alu && !load_req) flags_d = {Pre_C, Pre_V, Pre_Z, Pre_N};
            if (hlt) state_d = HALT;
`ifdef ILLEGAL_TRAP_EN
            if (!known && !load_req) begin
                state_d   = HALT;
                illegal_d = 1'b1;
            end
`endif
        end
        if (load_req) state_d = LOAD;
        else if (state_q != RUN && start) begin
            state_d = RUN;
            clr_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= LOAD;
            clr_q     <= 1'b0;
            flags_q   <= 4'd0;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_q     <= clr_d;
            flags_q   <= flags_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end
endmodule

// File: tb/tb_risc_control_unit.sv
// tb_risc_control_unit: vector table replayed through an expected-value queue, plus async-reset sequence.
module tb_risc_control_unit;
    typedef struct {
        int          id;
        logic        ld;
        logic        st;
        logic [15:0] ins;
        logic [3:0]  pre;
        logic [4:0]  md;
        logic [18:0] sb;
        logic [3:0]  fl;
        logic [15:0] rt;
    } vec_t;

    localparam logic [4:0] M_LD = 5'b10000, M_CL = 5'b01000, M_RN = 5'b00100,
                           M_HT = 5'b00010, M_IL = 5'b00011;
    localparam logic [18:0] B_ADC = 19'h1 << 18, B_SUB = 19'h1 << 17, B_SBB = 19'h1 << 16,
                            B_ALUB = 19'h1 << 15, B_RDB = 19'h1 << 14, B_JMP = 19'h1 << 13,
                            B_BR = 19'h1 << 12, B_LBL = 19'h1 << 11, B_RMPC = 19'h1 << 10,
                            B_DWE = 19'h1 << 8, B_RFW = 19'h1 << 7, B_MEM = 19'h1 << 6,
                            B_ALURF = 19'h1 << 5, B_PCRF = 19'h1 << 3, B_LHI = 19'h1 << 2,
                            B_LLI = 19'h1 << 1, B_OUT = 19'h1;

    logic        clk = 0, clr_n = 1, load_req = 0, start = 0;
    logic [15:0] instr = 0;
    logic        Pre_C = 0, Pre_V = 0, Pre_Z = 0, Pre_N = 0;
    logic        test_normal, clr, flag_HLT, ADC, SUB, SBB, Src_ALU_B, Src_Read_B;
    logic        JMP, BRANCH, flag_label_PC, flag_Rm_PC, flag_Rd_PC;
    logic        data_write_en, RF_write_en, flag_mem_RF, flag_ALU_RF, flag_Rm_RF, flag_PC_RF;
    logic        LHI, LLI, flag_OutR, halted, illegal;
    logic [3:0]  flags_q;
    logic [15:0] retired;
    logic [18:0] sb;
    logic [4:0]  md;

    int   total = 0, bad = 0;
    vec_t tbl[$];
    vec_t sbq[$];
    vec_t e, m;

    always #5 clk = ~clk;

    risc_control_unit #(.CNT_W(16)) dut (
        .clk(clk), .clr_n(clr_n), .load_req(load_req), .start(start), .instr(instr),
        .Pre_C(Pre_C), .Pre_V(Pre_V), .Pre_Z(Pre_Z), .Pre_N(Pre_N),
        .test_normal(test_normal), .clr(clr), .flag_HLT(flag_HLT),
        .ADC(ADC), .SUB(SUB), .SBB(SBB), .Src_ALU_B(Src_ALU_B), .Src_Read_B(Src_Read_B),
        .JMP(JMP), .BRANCH(BRANCH), .flag_label_PC(flag_label_PC), .flag_Rm_PC(flag_Rm_PC),
        .flag_Rd_PC(flag_Rd_PC), .data_write_en(data_write_en), .RF_write_en(RF_write_en),
        .flag_mem_RF(flag_mem_RF), .flag_ALU_RF(flag_ALU_RF), .flag_Rm_RF(flag_Rm_RF),
        .flag_PC_RF(flag_PC_RF), .LHI(LHI), .LLI(LLI), .flag_OutR(flag_OutR),
        .flags_q(flags_q), .halted(halted), .illegal(illegal), .retired(retired)
    );

    assign sb = {ADC, SUB, SBB, Src_ALU_B, Src_Read_B, JMP, BRANCH, flag_label_PC, flag_Rm_PC,
                 flag_Rd_PC, data_write_en, RF_write_en, flag_mem_RF, flag_ALU_RF, flag_Rm_RF,
                 flag_PC_RF, LHI, LLI, flag_OutR};
    assign md = {test_normal, clr, flag_HLT, halted, illegal};

    function automatic vec_t r(input logic ld, input logic st, input logic [15:0] ins,
                               input logic [3:0] pre, input logic [4:0] mdx,
                               input logic [18:0] sbx, input logic [3:0] fl, input logic [15:0] rt);
        vec_t v;
        v.id = 0; v.ld = ld; v.st = st; v.ins = ins; v.pre = pre;
        v.md = mdx; v.sb = sbx; v.fl = fl; v.rt = rt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        #2;
        while (sbq.size() > 0) begin
            m = sbq.pop_front();
            chk($sformatf("row%0d mode", m.id), {27'd0, md}, {27'd0, m.md});
            chk($sformatf("row%0d strobes", m.id), {13'd0, sb}, {13'd0, m.sb});
            chk($sformatf("row%0d flags", m.id), {28'd0, flags_q}, {28'd0, m.fl});
            chk($sformatf("row%0d retired", m.id), {16'd0, retired}, {16'd0, m.rt});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        tbl.push_back(r(0, 0, 16'h0000, 4'h0, M_LD, 0, 4'h0, 0));
        tbl.push_back(r(0, 1, 16'h0000, 4'h0, M_LD, 0, 4'h0, 0));
        tbl.push_back(r(0, 0, 16'h1900, 4'h0, M_CL, 0, 4'h0, 0));
        tbl.push_back(r(0, 0, 16'h1900, 4'h0, M_RN, B_ALUB | B_MEM | B_RFW, 4'h0, 0));
        tbl.push_back(r(0, 0, 16'h0328, 4'b1010, M_RN, B_ALURF | B_RFW, 4'h0, 1));
        tbl.push_back(r(0, 0, 16'hC000, 4'h0, M_RN, B_BR | B_LBL, 4'b1010, 2));
        tbl.push_back(r(0, 0, 16'h1900, 4'b0111, M_RN, B_ALUB | B_MEM | B_RFW, 4'b1010, 3));
        tbl.push_back(r(0, 0, 16'hC100, 4'h0, M_RN, 0, 4'b1010, 4));
        tbl.push_back(r(0, 0, 16'h0002, 4'b0001, M_RN, B_SUB | B_ALURF | B_RFW, 4'b1010, 5));
        tbl.push_back(r(0, 0, 16'hC400, 4'h0, M_RN, B_BR | B_LBL, 4'b0001, 6));
        tbl.push_back(r(0, 0, 16'h0001, 4'b0000, M_RN, B_ADC | B_ALURF | B_RFW, 4'b0001, 7));
        tbl.push_back(r(0, 0, 16'h0003, 4'b1000, M_RN, B_SBB | B_ALURF | B_RFW, 4'b0000, 8));
        tbl.push_back(r(0, 0, 16'hC200, 4'h0, M_RN, B_BR | B_LBL, 4'b1000, 9));
        tbl.push_back(r(0, 0, 16'hC600, 4'h0, M_RN, 0, 4'b1000, 10));
        tbl.push_back(r(0, 0, 16'h0800, 4'h0, M_RN, B_LHI | B_RDB | B_RFW, 4'b1000, 11));
        tbl.push_back(r(0, 0, 16'h1000, 4'h0, M_RN, B_LLI | B_RFW, 4'b1000, 12));
        tbl.push_back(r(0, 0, 16'h2800, 4'h0, M_RN, B_ALUB | B_RDB | B_DWE, 4'b1000, 13));
        tbl.push_back(r(0, 0, 16'hC800, 4'h0, M_RN, B_JMP | B_LBL, 4'b1000, 14));
        tbl.push_back(r(0, 0, 16'hD000, 4'h0, M_RN, B_JMP | B_RMPC, 4'b1000, 15));
        tbl.push_back(r(0, 0, 16'hD800, 4'h0, M_RN, B_JMP | B_LBL | B_PCRF | B_RFW, 4'b1000, 16));
        tbl.push_back(r(0, 0, 16'hE000, 4'h0, M_RN, B_OUT, 4'b1000, 17));
        tbl.push_back(r(0, 0, 16'hC700, 4'h0, M_RN, B_BR | B_LBL, 4'b1000, 18));
        tbl.push_back(r(0, 0, 16'hF800, 4'h0, M_RN, 0, 4'b1000, 19));
        tbl.push_back(r(0, 0, 16'h1900, 4'h0, M_HT, 0, 4'b1000, 20));
        tbl.push_back(r(0, 1, 16'h1900, 4'h0, M_HT, 0, 4'b1000, 20));
        tbl.push_back(r(0, 0, 16'h0000, 4'hF, M_CL, 0, 4'b1000, 20));
        tbl.push_back(r(0, 0, 16'hE000, 4'h0, M_RN, B_OUT, 4'b1000, 20));
        tbl.push_back(r(1, 0, 16'h2800, 4'h0, M_RN, B_ALUB | B_RDB, 4'b1000, 21));
        tbl.push_back(r(0, 0, 16'h0000, 4'h0, M_LD, 0, 4'b1000, 22));
        tbl.push_back(r(1, 1, 16'h0000, 4'h0, M_LD, 0, 4'b1000, 22));
        tbl.push_back(r(0, 0, 16'h0000, 4'h0, M_LD, 0, 4'b1000, 22));
        tbl.push_back(r(0, 1, 16'h0000, 4'h0, M_LD, 0, 4'b1000, 22));
        tbl.push_back(r(0, 0, 16'h3000, 4'h0, M_CL, 0, 4'b1000, 22));
        tbl.push_back(r(0, 0, 16'h3000, 4'h0, M_RN, 0, 4'b1000, 22));
`ifdef ILLEGAL_TRAP_EN
        tbl.push_back(r(0, 0, 16'h3000, 4'h0, M_IL, 0, 4'b1000, 23));
`else
        tbl.push_back(r(0, 0, 16'h3000, 4'h0, M_RN, 0, 4'b1000, 23));
`endif
        #1 clr_n = 0;
        #2;
        chk("reset mode", {27'd0, md}, {27'd0, M_LD});
        chk("reset strobes", {13'd0, sb}, 32'd0);
        chk("reset flags", {28'd0, flags_q}, 32'd0);
        chk("reset retired", {16'd0, retired}, 32'd0);
        @(negedge clk);
        clr_n = 1;
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            e = tbl[i];
            e.id = i;
            load_req = e.ld;
            start = e.st;
            instr = e.ins;
            {Pre_C, Pre_V, Pre_Z, Pre_N} = e.pre;
            sbq.push_back(e);
        end
        @(negedge clk);
        start = 0;
        load_req = 1;
        @(negedge clk);
        load_req = 0;
        start = 1;
        @(negedge clk);
        start = 0;
        instr = 16'h1900;
        @(negedge clk);
        #3;
        chk("pre-reset strobes", {13'd0, sb}, {13'd0, B_ALUB | B_MEM | B_RFW});
        chk("pre-reset mode", {27'd0, md}, {27'd0, M_RN});
        #1 clr_n = 0;
        #1;
        chk("async mode", {27'd0, md}, {27'd0, M_LD});
        chk("async strobes", {13'd0, sb}, 32'd0);
        chk("async flags", {28'd0, flags_q}, 32'd0);
        chk("async retired", {16'd0, retired}, 32'd0);
        @(negedge clk);
        clr_n = 1;
        @(negedge clk);
        #3;
        if (sbq.size() != 0) chk("queue drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
